// File: rtl/pcie_fc_credit_gate.sv
// pcie_fc_credit_gate
// Transmit-side PCIe flow-control credit gate. Posted, Non-Posted and
// Completion header/data credit limits (CL) and consumed counts (CC) are
// tracked per virtual channel from InitFC1/InitFC2/UpdateFC DLLPs. A TLP is
// offered on tlp_valid and issued on tlp_valid & tlp_ready.
// All credit arithmetic is modulo 2^W. A zero InitFC1 field advertises
// infinite credit for that field.
// Optional build macro PCIE_FC_WATCHDOG_EN adds a per-VC watchdog. The
// watchdog raises fc_timeout when a TLP stays blocked for UPDATE_TIMEOUT
// cycles without an UpdateFC arriving on its VC.
module pcie_fc_credit_gate #(
  parameter int NUM_VC         = 1,
  parameter int HDR_W          = 8,
  parameter int DATA_W         = 12,
  parameter int UPDATE_TIMEOUT = 100000
) (
  input  logic              sclk,
  input  logic              sreset_n,
  input  logic              link_up,
  input  logic              fc_valid,
  input  logic [1:0]        fc_kind,
  input  logic [2:0]        fc_vc,
  input  logic [1:0]        fc_type,
  input  logic [HDR_W-1:0]  fc_hdr,
  input  logic [DATA_W-1:0] fc_data,
  input  logic              tlp_valid,
  input  logic [2:0]        tlp_vc,
  input  logic [1:0]        tlp_type,
  input  logic [DATA_W-1:0] tlp_dcred,
  output logic              tlp_ready,
  output logic [NUM_VC-1:0] vc_active,
  output logic              fc_err,
  output logic              fc_timeout
);

  localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int VC_N = 1 << VC_W;

  localparam logic [1:0] FC_INIT1  = 2'd0;
  localparam logic [1:0] FC_INIT2  = 2'd1;
  localparam logic [1:0] FC_ACTIVE = 2'd2;

  localparam logic [1:0] K_INITFC1 = 2'd0;
  localparam logic [1:0] K_INITFC2 = 2'd1;
  localparam logic [1:0] K_UPDATE  = 2'd2;

  localparam logic [HDR_W-1:0]  HDR_ONE   = HDR_W'(1);
  localparam logic [HDR_W-1:0]  HDR_HALF  = {1'b1, {(HDR_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] DATA_HALF = {1'b1, {(DATA_W-1){1'b0}}};

  // Per-VC state; the inner [3] dimension is indexed by FC type (P/NP/Cpl).
  logic [1:0]        vc_state [VC_N];
  logic [2:0]        latched  [VC_N];
  logic [2:0]        inf_hdr  [VC_N];
  logic [2:0]        inf_data [VC_N];
  logic [HDR_W-1:0]  cl_hdr   [VC_N][3];
  logic [HDR_W-1:0]  cc_hdr   [VC_N][3];
  logic [DATA_W-1:0] cl_data  [VC_N][3];
  logic [DATA_W-1:0] cc_data  [VC_N][3];
  logic              fc_err_q;

  logic [VC_W-1:0]   t_vc, f_vc;
  logic [1:0]        t_ty, f_ty;
  logic              t_ok, f_ok, hs, same_slot, upd, upd_hdr_ok, upd_data_ok, upd_err;
  logic [HDR_W-1:0]  cc_hdr_post;
  logic [DATA_W-1:0] cc_data_post;

  // Credit check: the limit must still be at most half the counter space ahead of the used count.
  function automatic logic hdr_fits(input logic [HDR_W-1:0] limit, input logic [HDR_W-1:0] used);
    logic [HDR_W-1:0] gap;
    gap = limit - used;
    return gap <= HDR_HALF;
  endfunction

  function automatic logic data_fits(input logic [DATA_W-1:0] limit, input logic [DATA_W-1:0] used);
    logic [DATA_W-1:0] gap;
    gap = limit - used;
    return gap <= DATA_HALF;
  endfunction

  // Issue gate and UpdateFC acceptance, both decoded from registered credit state.
  always_comb begin
    // NOTE: every signal gets a value on entry so no path through this block infers a latch.
    t_vc         = tlp_vc[VC_W-1:0];
    t_ty         = (tlp_type == 2'd3) ? 2'd0 : tlp_type;
    t_ok         = (int'(tlp_vc) < NUM_VC) && (tlp_type != 2'd3);
    tlp_ready    = t_ok && (vc_state[t_vc] == FC_ACTIVE)
                 && (inf_hdr[t_vc][t_ty]  || hdr_fits(cl_hdr[t_vc][t_ty], cc_hdr[t_vc][t_ty] + HDR_ONE))
                 && (inf_data[t_vc][t_ty] || data_fits(cl_data[t_vc][t_ty], cc_data[t_vc][t_ty] + tlp_dcred));
    hs           = tlp_valid && tlp_ready;

    f_vc         = fc_vc[VC_W-1:0];
    f_ty         = (fc_type == 2'd3) ? 2'd0 : fc_type;
    f_ok         = fc_valid && (int'(fc_vc) < NUM_VC) && (fc_type != 2'd3);
    // An UpdateFC landing with a consume on the same slot is judged against the post-consume count.
    same_slot    = hs && (t_vc == f_vc) && (t_ty == f_ty);
    cc_hdr_post  = cc_hdr[f_vc][f_ty]  + (same_slot ? HDR_ONE : '0);
    cc_data_post = cc_data[f_vc][f_ty] + (same_slot ? tlp_dcred : '0);
    upd_hdr_ok   = hdr_fits(fc_hdr, cc_hdr_post);
    upd_data_ok  = data_fits(fc_data, cc_data_post);
    upd          = f_ok && (fc_kind == K_UPDATE) && (vc_state[f_vc] == FC_ACTIVE);
    upd_err      = upd && ((inf_hdr[f_vc][f_ty]  ? (fc_hdr  != '0) : !upd_hdr_ok)
                        || (inf_data[f_vc][f_ty] ? (fc_data != '0) : !upd_data_ok));
  end

  // Per-VC init FSM, credit limits, consumed counters and the sticky protocol error.
  always_ff @(posedge sclk or negedge sreset_n) begin
    if (!sreset_n) begin
      fc_err_q <= 1'b0;
      // NOTE: the credit arrays are plain flops, so every entry is reset explicitly.
      for (int v = 0; v < VC_N; v++) begin
        vc_state[v] <= FC_INIT1;
        latched[v]  <= '0;
        inf_hdr[v]  <= '0;
        inf_data[v] <= '0;
        for (int t = 0; t < 3; t++) begin
          cl_hdr[v][t]  <= '0;
          cc_hdr[v][t]  <= '0;
          cl_data[v][t] <= '0;
          cc_data[v][t] <= '0;
        end
      end
    end else begin
      // NOTE: state uses <= so every flop samples pre-edge values whatever the statement order.
      if (upd_err) fc_err_q <= 1'b1;
      for (int v = 0; v < VC_N; v++) begin
        if (!link_up) begin
          vc_state[v] <= FC_INIT1;
          latched[v]  <= '0;
          inf_hdr[v]  <= '0;
          inf_data[v] <= '0;
          for (int t = 0; t < 3; t++) begin
            cl_hdr[v][t]  <= '0;
            cc_hdr[v][t]  <= '0;
            cl_data[v][t] <= '0;
            cc_data[v][t] <= '0;
          end
        end else begin
          if (hs && (t_vc == VC_W'(v))) begin
            cc_hdr[v][t_ty]  <= cc_hdr[v][t_ty] + HDR_ONE;
            cc_data[v][t_ty] <= cc_data[v][t_ty] + tlp_dcred;
          end
          if (f_ok && (f_vc == VC_W'(v))) begin
            case (vc_state[v])
              FC_INIT1: if (fc_kind == K_INITFC1) begin
                cl_hdr[v][f_ty]   <= fc_hdr;
                cl_data[v][f_ty]  <= fc_data;
                inf_hdr[v][f_ty]  <= (fc_hdr == '0);
                inf_data[v][f_ty] <= (fc_data == '0);
                latched[v][f_ty]  <= 1'b1;
                if ((latched[v] | (3'b001 << f_ty)) == 3'b111) vc_state[v] <= FC_INIT2;
              end
              FC_INIT2: if ((fc_kind == K_INITFC2) || (fc_kind == K_UPDATE)) vc_state[v] <= FC_ACTIVE;
              FC_ACTIVE: if (fc_kind == K_UPDATE) begin
                if (!inf_hdr[v][f_ty] && upd_hdr_ok)   cl_hdr[v][f_ty]  <= fc_hdr;
                if (!inf_data[v][f_ty] && upd_data_ok) cl_data[v][f_ty] <= fc_data;
              end
              default: vc_state[v] <= FC_INIT1;
            endcase
          end
        end
      end
    end
  end

  // Per-VC FC_ACTIVE flags.
  always_comb begin
    vc_active = '0;
    for (int v = 0; v < NUM_VC; v++) vc_active[v] = (vc_state[v] == FC_ACTIVE);
  end

  assign fc_err = fc_err_q;

`ifdef PCIE_FC_WATCHDOG_EN
  localparam int WD_W = $clog2(UPDATE_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(UPDATE_TIMEOUT);

  logic [WD_W-1:0] wd_cnt [VC_N];
  logic            fc_timeout_q;

  // Blocked-cycle counter per VC; any UpdateFC to the VC restarts it, and it saturates at the limit.
  always_ff @(posedge sclk or negedge sreset_n) begin
    if (!sreset_n) begin
      fc_timeout_q <= 1'b0;
      for (int v = 0; v < VC_N; v++) wd_cnt[v] <= '0;
    end else begin
      for (int v = 0; v < VC_N; v++) begin
        if (!link_up) begin
          wd_cnt[v] <= '0;
        end else if (fc_valid && (fc_kind == K_UPDATE) && (fc_vc == 3'(v))) begin
          wd_cnt[v] <= '0;
        end else if ((vc_state[v] == FC_ACTIVE) && tlp_valid && !tlp_ready && (tlp_vc == 3'(v))) begin
          if (wd_cnt[v] != WD_MAX) wd_cnt[v] <= wd_cnt[v] + WD_W'(1);
          if (wd_cnt[v] >= WD_MAX - WD_W'(1)) fc_timeout_q <= 1'b1;
        end
      end
    end
  end

  assign fc_timeout = fc_timeout_q;
`else
  // No watchdog is built; a negative limit is meaningless, so this is constant low.
  assign fc_timeout = (UPDATE_TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_pcie_fc_credit_gate.sv
// tb_pcie_fc_credit_gate
// Directed bench for pcie_fc_credit_gate (NUM_VC=1, HDR_W=8, DATA_W=12).
// A vector table covers init, exhaustion, gating boundaries and same-cycle
// update/consume. Hand-written sequences cover wrap-around, protocol errors,
// reset, link drop and the watchdog when PCIE_FC_WATCHDOG_EN is defined.
module tb_pcie_fc_credit_gate;

  localparam logic [1:0] I1 = 2'd0, I2 = 2'd1, UP = 2'd2, RS = 2'd3;
  localparam logic [1:0] P = 2'd0, NP = 2'd1, CPL = 2'd2, T3 = 2'd3;

  logic        sclk = 1'b0;
  logic        sreset_n = 1'b0;
  logic        link_up = 1'b1;
  logic        fc_valid = 1'b0;
  logic [1:0]  fc_kind = '0;
  logic [2:0]  fc_vc = '0;
  logic [1:0]  fc_type = '0;
  logic [7:0]  fc_hdr = '0;
  logic [11:0] fc_data = '0;
  logic        tlp_valid = 1'b0;
  logic [2:0]  tlp_vc = '0;
  logic [1:0]  tlp_type = '0;
  logic [11:0] tlp_dcred = '0;
  logic        tlp_ready;
  logic [0:0]  vc_active;
  logic        fc_err;
  logic        fc_timeout;

  int total = 0;
  int bad = 0;

  pcie_fc_credit_gate #(
    .NUM_VC(1), .HDR_W(8), .DATA_W(12), .UPDATE_TIMEOUT(50)
  ) dut (
    .sclk(sclk), .sreset_n(sreset_n), .link_up(link_up),
    .fc_valid(fc_valid), .fc_kind(fc_kind), .fc_vc(fc_vc), .fc_type(fc_type),
    .fc_hdr(fc_hdr), .fc_data(fc_data),
    .tlp_valid(tlp_valid), .tlp_vc(tlp_vc), .tlp_type(tlp_type), .tlp_dcred(tlp_dcred),
    .tlp_ready(tlp_ready), .vc_active(vc_active), .fc_err(fc_err), .fc_timeout(fc_timeout)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic        fv;
    logic [1:0]  fk;
    logic [1:0]  ft;
    logic [7:0]  fh;
    logic [11:0] fd;
    logic        tv;
    logic [1:0]  tt;
    logic [2:0]  tvc;
    logic [11:0] dc;
    logic        chk;
    logic        er;
    logic        ea;
  } vec_t;

  function automatic vec_t mk(logic fv, logic [1:0] fk, logic [1:0] ft, logic [7:0] fh,
                              logic [11:0] fd, logic tv, logic [1:0] tt, logic [2:0] tvc,
                              logic [11:0] dc, logic chk, logic er, logic ea);
    vec_t r;
    r.fv = fv; r.fk = fk; r.ft = ft; r.fh = fh; r.fd = fd;
    r.tv = tv; r.tt = tt; r.tvc = tvc; r.dc = dc;
    r.chk = chk; r.er = er; r.ea = ea;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fc(input logic [1:0] k, input logic [1:0] t, input logic [7:0] h, input logic [11:0] d);
    fc_valid = 1'b1; fc_kind = k; fc_vc = 3'd0; fc_type = t; fc_hdr = h; fc_data = d;
  endtask

  task automatic tlp(input logic v, input logic [1:0] t, input logic [11:0] dc);
    tlp_valid = v; tlp_vc = 3'd0; tlp_type = t; tlp_dcred = dc;
  endtask

  // Advance one clock; inputs are dropped at the falling edge, ready for the next cycle.
  task automatic step();
    @(posedge sclk);
    @(negedge sclk);
    fc_valid = 1'b0;
    tlp_valid = 1'b0;
  endtask

  task automatic init_vc0();
    fc(I1, P, 8'd4, 12'd64);   step();
    fc(I1, NP, 8'd2, 12'd0);   step();
    fc(I1, CPL, 8'd0, 12'd0);  step();
    fc(I2, P, 8'd4, 12'd64);   step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t vt[29];
    int   wrap_bad;

    //      fv fk  ft   fh   fd    tv tt   tvc dc    chk er ea
    vt[0]  = mk(0, I1, P,   0,   0,    0, P,   0, 0,    1, 0, 0);
    vt[1]  = mk(1, I1, P,   4,   64,   1, P,   0, 0,    1, 0, 0);
    vt[2]  = mk(1, I1, NP,  2,   0,    0, P,   0, 0,    1, 0, 0);
    vt[3]  = mk(1, I1, CPL, 0,   0,    0, P,   0, 0,    1, 0, 0);
    vt[4]  = mk(0, I1, P,   0,   0,    0, P,   0, 0,    1, 0, 0);
    vt[5]  = mk(1, I2, P,   4,   64,   0, P,   0, 0,    1, 0, 0);
    vt[6]  = mk(0, I1, P,   0,   0,    0, P,   0, 0,    0, 0, 0);
    vt[7]  = mk(0, I1, P,   0,   0,    0, P,   0, 16,   1, 1, 1);
    vt[8]  = mk(0, I1, P,   0,   0,    1, P,   0, 16,   1, 1, 1);
    vt[9]  = mk(0, I1, P,   0,   0,    1, P,   0, 16,   1, 1, 1);
    vt[10] = mk(0, I1, P,   0,   0,    1, P,   0, 16,   1, 1, 1);
    vt[11] = mk(0, I1, P,   0,   0,    1, P,   0, 16,   1, 1, 1);
    vt[12] = mk(0, I1, P,   0,   0,    1, P,   0, 16,   1, 0, 1);
    vt[13] = mk(1, UP, P,   5,   80,   1, P,   0, 16,   1, 0, 1);
    vt[14] = mk(0, I1, P,   0,   0,    1, P,   0, 16,   1, 1, 1);
    vt[15] = mk(0, I1, P,   0,   0,    0, P,   0, 0,    1, 0, 1);
    vt[16] = mk(1, UP, P,   10,  80,   0, P,   0, 1,    1, 0, 1);
    vt[17] = mk(0, I1, P,   0,   0,    0, P,   0, 1,    1, 0, 1);
    vt[18] = mk(0, I1, P,   0,   0,    0, P,   0, 0,    1, 1, 1);
    vt[19] = mk(1, UP, P,   134, 96,   1, P,   0, 0,    1, 1, 1);
    vt[20] = mk(0, I1, P,   0,   0,    0, P,   0, 16,   1, 1, 1);
    vt[21] = mk(0, I1, P,   0,   0,    0, P,   0, 17,   1, 0, 1);
    vt[22] = mk(0, I1, P,   0,   0,    0, T3,  0, 0,    1, 0, 1);
    vt[23] = mk(0, I1, P,   0,   0,    0, P,   1, 0,    1, 0, 1);
    vt[24] = mk(0, I1, P,   0,   0,    0, CPL, 0, 4095, 1, 1, 1);
    vt[25] = mk(0, I1, P,   0,   0,    0, NP,  0, 4095, 1, 1, 1);
    vt[26] = mk(1, RS, P,   200, 0,    0, P,   0, 16,   1, 1, 1);
    vt[27] = mk(1, UP, T3,  0,   0,    0, P,   0, 16,   1, 1, 1);
    vt[28] = mk(0, I1, P,   0,   0,    0, P,   0, 16,   1, 1, 1);

    // Reset state, with a TLP offered.
    @(negedge sclk);
    tlp(1, P, 12'd0);
    #1;
    check("rst_ready", tlp_ready, 0);
    check("rst_active", vc_active, 0);
    check("rst_err", fc_err, 0);
    check("rst_timeout", fc_timeout, 0);
    step();
    sreset_n = 1'b1;
    step();

    // Table: init handshake, exhaustion, gate boundaries, same-cycle update/consume.
    for (int i = 0; i < 29; i++) begin
      fc_valid = vt[i].fv; fc_kind = vt[i].fk; fc_vc = 3'd0; fc_type = vt[i].ft;
      fc_hdr = vt[i].fh; fc_data = vt[i].fd;
      tlp_valid = vt[i].tv; tlp_type = vt[i].tt; tlp_vc = vt[i].tvc; tlp_dcred = vt[i].dc;
      #1;
      if (vt[i].chk) begin
        check($sformatf("v%0d_ready", i), tlp_ready, vt[i].er);
        check($sformatf("v%0d_active", i), vc_active, vt[i].ea);
        check($sformatf("v%0d_err", i), fc_err, 0);
      end
      step();
    end

    // Wrap-around on NP header: drive CC_hdr to 254 with a trailing limit.
    wrap_bad = 0;
    for (int i = 0; i < 254; i++) begin
      fc(UP, NP, 8'(i + 2), 12'd0);
      tlp(1, NP, 12'd0);
      #1;
      if (tlp_ready !== 1'b1) wrap_bad++;
      step();
    end
    check("wrap_fill_blocked", wrap_bad, 0);
    check("wrap_fill_err", fc_err, 0);
    fc(UP, NP, 8'd2, 12'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      tlp(1, NP, 12'd0);
      #1;
      check($sformatf("wrap_accept%0d", k), tlp_ready, 1);
      step();
    end
    tlp(1, NP, 12'd0);
    fc(UP, NP, 8'd6, 12'd0);
    #1;
    check("wrap_block", tlp_ready, 0);
    step();
    tlp(0, NP, 12'd0);
    #1;
    check("wrap_reopen", tlp_ready, 1);
    check("wrap_err", fc_err, 0);

    // Non-zero UpdateFC on the infinite NP data field.
    fc(UP, NP, 8'd6, 12'd5);
    step();
    tlp(0, NP, 12'd4095);
    #1;
    check("inf_err", fc_err, 1);
    check("inf_still_inf", tlp_ready, 1);

    // Asynchronous reset mid-run clears everything, including the sticky error.
    sreset_n = 1'b0;
    tlp(1, CPL, 12'd0);
    #1;
    check("rst2_ready", tlp_ready, 0);
    check("rst2_active", vc_active, 0);
    check("rst2_err", fc_err, 0);
    step();
    sreset_n = 1'b1;
    step();
    init_vc0();
    #1;
    check("reinit_active", vc_active, 1);

    // Out-of-window UpdateFC on P header: header kept, data updated, fc_err set.
    for (int k = 0; k < 2; k++) begin
      tlp(1, P, 12'd16);
      #1;
      check($sformatf("perr_pre%0d", k), tlp_ready, 1);
      step();
    end
    fc(UP, P, 8'd202, 12'd48);
    step();
    #1;
    check("perr_err", fc_err, 1);
    tlp(0, P, 12'd16);
    #1;
    check("perr_data_new", tlp_ready, 1);
    tlp(0, P, 12'd17);
    #1;
    check("perr_data_edge", tlp_ready, 0);
    for (int k = 0; k < 2; k++) begin
      tlp(1, P, 12'd0);
      #1;
      check($sformatf("perr_use%0d", k), tlp_ready, 1);
      step();
    end
    tlp(1, P, 12'd0);
    #1;
    check("perr_hdr_kept", tlp_ready, 0);

    // Link drop for one cycle mid-traffic.
    tlp(1, CPL, 12'd0);
    #1;
    check("drop_pre_ready", tlp_ready, 1);
    step();
    link_up = 1'b0;
    tlp(1, CPL, 12'd0);
    step();
    link_up = 1'b1;
    tlp(1, CPL, 12'd0);
    #1;
    check("drop_active", vc_active, 0);
    check("drop_ready", tlp_ready, 0);
    check("drop_err_held", fc_err, 1);
    step();
    fc(I2, P, 8'd4, 12'd64);
    step();
    step();
    #1;
    check("drop_need_init", vc_active, 0);
    init_vc0();
    tlp(0, P, 12'd64);
    #1;
    check("drop_reinit_active", vc_active, 1);
    check("drop_cc_cleared", tlp_ready, 1);

    // Blocked TLP against the watchdog limit of 50 cycles.
`ifdef PCIE_FC_WATCHDOG_EN
    for (int k = 0; k < 49; k++) begin
      tlp(1, P, 12'd65);
      step();
    end
    #1;
    check("wd_before_limit", fc_timeout, 0);
    tlp(1, P, 12'd65);
    step();
    #1;
    check("wd_at_limit", fc_timeout, 1);
`else
    for (int k = 0; k < 60; k++) begin
      tlp(1, P, 12'd65);
      step();
    end
    #1;
    check("wd_absent", fc_timeout, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcie_fc_credit_gate.md
Name: pcie_fc_credit_gate

Overview:
- Transmit-side PCIe flow-control credit gate for the Data Link / Transaction layer boundary.
- Tracks Posted (P), Non-Posted (NP) and Completion (Cpl) header/data credits per virtual channel from received InitFC1/InitFC2/UpdateFC DLLPs.
- Gates TLP issue with a valid/ready handshake.
- Generalises single-VC, fixed-width FC handling to NUM_VC channels, parametrised credit widths (scaled FC) and infinite-credit advertisement.

Parameters:
- NUM_VC, 1, number of virtual channels (1..8).
- HDR_W, 8, header credit counter width (10 for scaled FC).
- DATA_W, 12, data credit counter width (14 for scaled FC).
- UPDATE_TIMEOUT, 100000, sclk cycles for the FC update watchdog (optional feature only).

Ports:
- sclk  in  1  clock.
- sreset_n  in  1  asynchronous active-low reset.
- link_up  in  1  DL_Up; a low level returns every VC to FC_INIT1.
- fc_valid  in  1  one decoded FC DLLP this cycle (CRC already checked).
- fc_kind  in  2  0=InitFC1, 1=InitFC2, 2=UpdateFC, 3=reserved (ignored).
- fc_vc  in  3  VC id; values >= NUM_VC are ignored.
- fc_type  in  2  0=P, 1=NP, 2=Cpl, 3 ignored.
- fc_hdr  in  HDR_W  HdrFC field.
- fc_data  in  DATA_W  DataFC field.
- tlp_valid  in  1  TLP ready to issue.
- tlp_vc  in  3  TLP VC.
- tlp_type  in  2  TLP FC type.
- tlp_dcred  in  DATA_W  data credits needed (payload DW / 4, rounded up; 0 if no payload).
- tlp_ready  out  1  credits sufficient; consume on tlp_valid & tlp_ready.
- vc_active  out  NUM_VC  per-VC FC_ACTIVE flag.
- fc_err  out  1  sticky FC protocol error.
- fc_timeout  out  1  sticky watchdog flag (0 when feature is compiled out).

Behaviour:
- Reset (async): all VCs in FC_INIT1; CL and CC = 0; infinite flags = 0; tlp_ready=0; vc_active=0; fc_err=0; fc_timeout=0.
- Per-VC FSM:
  - FC_INIT1: an InitFC1 for type t latches CL_hdr[t]=fc_hdr and CL_data[t]=fc_data. A zero field sets that field's infinite flag. Once all three types are latched, go to FC_INIT2 next cycle. A repeated InitFC1 for a type overwrites its values.
  - FC_INIT2: InitFC1 ignored. The first InitFC2 or UpdateFC for this VC moves it to FC_ACTIVE next cycle.
  - FC_ACTIVE: InitFC1/InitFC2 ignored. UpdateFC applies to non-infinite fields only.
  - link_up=0 in any state: next cycle FC_INIT1 and all counters/flags cleared. fc_err and fc_timeout are held.
- Credit arithmetic, modulo 2^W per field: CC += consumed; CL is replaced by the UpdateFC value.
- Gate test, with W = field width: (CL - (CC + need)) mod 2^W <= 2^(W-1).
  - Header need = 1; data need = tlp_dcred.
  - An infinite field always passes.
- tlp_ready is combinational from registered state and tlp_vc/tlp_type. It is 1 only when the VC is FC_ACTIVE, the type is valid, and both fields pass. Otherwise 0.
- Consumption on handshake: CC_hdr += 1 and CC_data += tlp_dcred, visible the next cycle. No other latency.
- Consumption and UpdateFC on the same VC/type in the same cycle: both apply. The new CL is checked against the post-consume CC.
- UpdateFC with (CL_new - CC) mod 2^W > 2^(W-1): that field is not updated and fc_err is set.
- Non-zero UpdateFC on an infinite field: value is ignored and fc_err is set.
- Wrap-around of CC/CL past 2^W - 1 is legal and transparent.

Optional Feature:
- Macro: PCIE_FC_WATCHDOG_EN.
- With the macro: a per-VC counter, reset by any UpdateFC to that VC.
  - It increments while the VC is FC_ACTIVE and tlp_valid is held with tlp_ready=0 on that VC.
  - Reaching UPDATE_TIMEOUT sets fc_timeout (sticky) and saturates the counter.
  - link_up=0 clears the counters.
- Without the macro: no counters are built and fc_timeout is tied to 0.

Test Plan:
- Init handshake (W=8/12): InitFC1 P=(4,64), NP=(2,0), Cpl=(0,0), then InitFC2 P -> vc_active[0]=1 on the 2nd cycle after InitFC2. NP data and Cpl hdr/data are infinite.
- Credit exhaustion: P limit (4,64); issue 4 TLPs with dcred=16 -> all accepted. 5th TLP: tlp_ready=0. UpdateFC P=(5,80) -> tlp_ready=1 the next cycle.
- Wrap-around: CL_hdr=2, CC_hdr=254 (HDR_W=8) -> 4 TLPs accepted, then ready=0 until UpdateFC hdr=6.
- Simultaneous: TLP handshake and UpdateFC on the same type in one cycle -> CC advances and CL is updated; no fc_err.
- Errors: UpdateFC P hdr = CC+200 (W=8) -> CL unchanged, fc_err=1. Non-zero UpdateFC on infinite NP data -> fc_err=1.
- Link drop mid-traffic: link_up=0 for 1 cycle -> vc_active=0, tlp_ready=0. A fresh init is required. With PCIE_FC_WATCHDOG_EN and UPDATE_TIMEOUT=50, a blocked TLP for 50 cycles sets fc_timeout=1.
